// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master (all four modes, MSB/LSB first,
// configurable frame width N and SCLK half-period DIV).
// Optional feature macro: SPIM_LOOPBACK_EN adds a `loopback` input that
// routes the internal MOSI value into the receive path instead of MISO.
`timescale 1ns/1ps

module spi_master_param #(
   parameter int N   = 15,
   parameter int DIV = 25
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         st,
   input  logic [1:0]   mode,
   input  logic         lsb_first,
   input  logic [N-1:0] DI,
   input  logic         MISO,
`ifdef SPIM_LOOPBACK_EN
   input  logic         loopback,
`endif
   output logic         MOSI,
   output logic         SCLK,
   output logic         LOAD,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] DO
);

   localparam int CW = $clog2(DIV + 1);
   localparam int EW = $clog2(2 * N + 1);
   localparam logic [CW-1:0] C_RELOAD = CW'(DIV - 1);
   localparam logic [EW-1:0] C_LAST   = EW'(2 * N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LEAD,
      S_SHIFT,
      S_TRAIL
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic [CW-1:0]  r_cnt;
   logic [EW-1:0]  r_edge;
   logic [N-1:0]   r_tx;
   logic [N-1:0]   r_rx;
   logic [N-1:0]   r_do;
   logic           r_cpol;
   logic           r_cpha;
   logic           r_lsb;
   logic           r_sclk;
   logic           r_mosi;
   logic           r_load;
   logic           r_busy;
   logic           r_done;

   logic           w_cnt_zero;
   logic           w_start;
   logic           w_edge;
   logic           w_finish;
   logic           w_lead;
   logic           w_first;
   logic           w_sample;
   logic           w_drive;
   logic           w_tx_cur;
   logic           w_tx_nxt;
   logic [N-1:0]   w_tx_shift;
   logic           w_di_first;
   logic           w_rx_bit;
   logic [N-1:0]   w_rx_shift;

   assign w_cnt_zero = (r_cnt == '0);

   // The edge about to be produced is number r_edge+1; odd numbers are leading.
   assign w_lead   = ~r_edge[0];
   assign w_first  = (r_edge == '0);
   assign w_sample = w_edge & (r_cpha ? ~w_lead : w_lead);
   assign w_drive  = w_edge & (r_cpha ? w_lead : ~w_lead);

   // Bit currently at the head of the tx register and the one behind it.
   assign w_tx_cur   = r_lsb ? r_tx[0] : r_tx[N-1];
   assign w_tx_nxt   = r_lsb ? r_tx[1] : r_tx[N-2];
   assign w_tx_shift = r_lsb ? {1'b0, r_tx[N-1:1]} : {r_tx[N-2:0], 1'b0};
   assign w_di_first = lsb_first ? DI[0] : DI[N-1];

`ifdef SPIM_LOOPBACK_EN
   assign w_rx_bit = loopback ? r_mosi : MISO;
`else
   assign w_rx_bit = MISO;
`endif

   // MSB-first fills from bit 0 upward; LSB-first fills from the top down.
   assign w_rx_shift = r_lsb ? {w_rx_bit, r_rx[N-1:1]} : {r_rx[N-2:0], w_rx_bit};

   // State register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_edge      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (st) begin
               w_start     = 1'b1;
               w_state_nxt = S_LEAD;
            end
         end
         S_LEAD: begin
            if (w_cnt_zero) begin
               w_edge      = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_cnt_zero) begin
               w_edge = 1'b1;
               if (r_edge == C_LAST) w_state_nxt = S_TRAIL;
            end
         end
         S_TRAIL: begin
            if (w_cnt_zero) begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Half-period timer: reloaded at frame start and at every SCLK edge, holds at zero.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)                                       r_cnt <= '0;
      else if (w_start || w_edge)                    r_cnt <= C_RELOAD;
      else if ((r_state != S_IDLE) && !w_cnt_zero)   r_cnt <= r_cnt - CW'(1);
   end

   // SCLK edge counter.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)          r_edge <= '0;
      else if (w_start) r_edge <= '0;
      else if (w_edge)  r_edge <= r_edge + EW'(1);
   end

   // Per-frame configuration captured at start.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_cpol <= 1'b0;
         r_cpha <= 1'b0;
         r_lsb  <= 1'b0;
      end else if (w_start) begin
         r_cpol <= mode[1];
         r_cpha <= mode[0];
         r_lsb  <= lsb_first;
      end
   end

   // Transmit and receive shift registers (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (w_start) begin
         r_tx <= DI;
         r_rx <= '0;
      end else begin
         if (w_drive && !(r_cpha && w_first)) r_tx <= w_tx_shift;
         if (w_sample)                        r_rx <= w_rx_shift;
      end
   end

   // MOSI: first bit at LOAD fall for CPHA=0, at the first edge for CPHA=1.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)           r_mosi <= 1'b0;
      else if (w_start)  r_mosi <= mode[0] ? 1'b0 : w_di_first;
      else if (w_finish) r_mosi <= 1'b0;
      else if (w_drive)  r_mosi <= (r_cpha && w_first) ? w_tx_cur : w_tx_nxt;
   end

   // SCLK idles at the latched CPOL and toggles on every edge strobe.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)          r_sclk <= 1'b0;
      else if (w_start) r_sclk <= mode[1];
      else if (w_edge)  r_sclk <= ~r_sclk;
   end

   // Handshake outputs and received-word register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_load <= 1'b1;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_do   <= '0;
      end else begin
         r_done <= w_finish;
         if (w_start) begin
            r_load <= 1'b0;
            r_busy <= 1'b1;
         end else if (w_finish) begin
            r_load <= 1'b1;
            r_busy <= 1'b0;
            r_do   <= r_rx;
         end
      end
   end

   assign MOSI = r_mosi;
   assign SCLK = r_sclk;
   assign LOAD = r_load;
   assign busy = r_busy;
   assign done = r_done;
   assign DO   = r_do;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed testbench for spi_master_param (N=15, DIV=25) with a small SPI
// slave model that captures MOSI and drives MISO for the selected mode.
`timescale 1ns/1ps

module tb_spi_master_param;

   localparam int N   = 15;
   localparam int DIV = 25;
   localparam int FRAME = (2 * N + 1) * DIV;

   logic         clk;
   logic         clr;
   logic         st;
   logic [1:0]   mode;
   logic         lsb_first;
   logic [N-1:0] DI;
   logic         MISO;
   logic         MOSI;
   logic         SCLK;
   logic         LOAD;
   logic         busy;
   logic         done;
   logic [N-1:0] DO;
`ifdef SPIM_LOOPBACK_EN
   logic         loopback;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // slave model state
   logic         s_cpha;
   logic         s_lsb;
   logic [N-1:0] s_tx;
   logic [N-1:0] s_cap;
   int           s_edge;
   int           s_rise;
   int           s_bad;

   spi_master_param #(.N(N), .DIV(DIV)) dut (
      .clk       (clk),
      .clr       (clr),
      .st        (st),
      .mode      (mode),
      .lsb_first (lsb_first),
      .DI        (DI),
      .MISO      (MISO),
`ifdef SPIM_LOOPBACK_EN
      .loopback  (loopback),
`endif
      .MOSI      (MOSI),
      .SCLK      (SCLK),
      .LOAD      (LOAD),
      .busy      (busy),
      .done      (done),
      .DO        (DO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic sbit(input int j);
      if (j >= N) return 1'b0;
      return s_lsb ? s_tx[j] : s_tx[N-1-j];
   endfunction

   // Slave model: watches pins on the falling clk edge.
   initial begin : slave
      logic m_load_q, m_sclk_q, m_mosi_q;
      logic lead, samp;
      int   j;
      MISO = 1'b0;
      m_load_q = 1'b1; m_sclk_q = 1'b0; m_mosi_q = 1'b0;
      s_edge = 0; s_rise = 0; s_bad = 0; s_cap = '0;
      forever begin
         @(negedge clk);
         if (m_load_q === 1'b1 && LOAD === 1'b0) begin
            s_edge = 0; s_rise = 0; s_bad = 0; s_cap = '0;
            if (!s_cpha) MISO = sbit(0);
         end else if (LOAD === 1'b0 && SCLK !== m_sclk_q) begin
            s_edge++;
            if (SCLK === 1'b1) s_rise++;
            lead = (s_edge % 2) == 1;
            samp = s_cpha ? !lead : lead;
            j = (s_edge - 1) / 2;
            if (samp) begin
               if (j < N) s_cap[s_lsb ? j : N-1-j] = MOSI;
               if (MOSI !== m_mosi_q) s_bad++;
            end else begin
               MISO = s_cpha ? sbit(j) : sbit(s_edge / 2);
            end
         end else if (LOAD === m_load_q && MOSI !== m_mosi_q) begin
            s_bad++;
         end
         m_load_q = LOAD; m_sclk_q = SCLK; m_mosi_q = MOSI;
      end
   end

   // Must be called just after a falling clk edge; returns at the falling edge where done is seen.
   task automatic run_frame(input logic [1:0] md, input logic lsb, input logic [N-1:0] di,
                            input logic [N-1:0] stx, input bit poke, output int lat);
      s_cpha = md[0]; s_lsb = lsb; s_tx = stx;
      mode = md; lsb_first = lsb; DI = di; st = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int j = 0; j < 2000; j++) begin
         @(negedge clk);
         if (j == 0) begin
            st = 1'b0;
            check("load_fall", LOAD, 1'b0);
            check("busy_rise", busy, 1'b1);
            mode = ~md; lsb_first = ~lsb; DI = ~di;
         end
         if (poke) begin
            if (j == 100 || j == 400) st = 1'b1;
            if (j == 101 || j == 401) st = 1'b0;
         end
         if (done === 1'b1) begin
            lat = j;
            break;
         end
      end
   endtask

   task automatic post_checks(input string tag, input int lat, input logic [N-1:0] exp_do,
                              input logic [N-1:0] exp_cap);
      check({tag, "_latency"}, lat, FRAME);
      check({tag, "_DO"}, DO, exp_do);
      check({tag, "_slave_cap"}, s_cap, exp_cap);
      check({tag, "_sclk_rises"}, s_rise, N);
      check({tag, "_mosi_off_edge"}, s_bad, 0);
      check({tag, "_load_hi"}, LOAD, 1'b1);
      check({tag, "_busy_lo"}, busy, 1'b0);
   endtask

   initial begin : main
      int  lat;
      bit  found;
      clr = 1'b0; st = 1'b0; mode = 2'b00; lsb_first = 1'b0; DI = '0;
      s_cpha = 1'b0; s_lsb = 1'b0; s_tx = '0;
`ifdef SPIM_LOOPBACK_EN
      loopback = 1'b0;
`endif
      // asynchronous reset with st high, before any clock edge
      #1 clr = 1'b1; st = 1'b1;
      #1;
      check("rst_LOAD", LOAD, 1'b1);
      check("rst_SCLK", SCLK, 1'b0);
      check("rst_MOSI", MOSI, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_DO", DO, '0);
      repeat (3) @(negedge clk);
      check("rst_hold_LOAD", LOAD, 1'b1);
      check("rst_hold_busy", busy, 1'b0);
      clr = 1'b0; st = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_LOAD", LOAD, 1'b1);

      // mode 0, MSB first, MISO held high
      run_frame(2'b00, 1'b0, 15'b111110000110011, 15'h7FFF, 1'b0, lat);
      post_checks("m0", lat, 15'h7FFF, 15'h7C33);
      @(negedge clk);
      check("m0_done_pulse", done, 1'b0);
      repeat (3) @(negedge clk);

      // mode 1, MISO low, then mode 2 back-to-back
      run_frame(2'b01, 1'b0, 15'h2A55, 15'h0000, 1'b0, lat);
      post_checks("m1", lat, 15'h0000, 15'h2A55);
      check("b2b_gap_load_hi", LOAD, 1'b1);
      run_frame(2'b10, 1'b0, 15'h2A55, 15'h0000, 1'b0, lat);
      post_checks("m2", lat, 15'h0000, 15'h2A55);
      check("m2_sclk_end", SCLK, 1'b1);
      repeat (3) @(negedge clk);

      // mode 3, LSB first, with ignored st pulses during the frame
      run_frame(2'b11, 1'b1, 15'h0F0F, 15'h1234, 1'b1, lat);
      post_checks("m3", lat, 15'h1234, 15'h0F0F);
      repeat (5) @(negedge clk);
      check("m3_sclk_idle_hi", SCLK, 1'b1);
      check("m3_no_restart", LOAD, 1'b1);

      // reset while idle: SCLK and DO return to zero without a clock edge
      clr = 1'b1;
      #1;
      check("idle_rst_SCLK", SCLK, 1'b0);
      check("idle_rst_DO", DO, '0);
      check("idle_rst_LOAD", LOAD, 1'b1);
      @(negedge clk);
      clr = 1'b0;
      repeat (2) @(negedge clk);

      // abort at SCLK edge 7
      s_cpha = 1'b0; s_lsb = 1'b0; s_tx = 15'h7FFF;
      mode = 2'b00; lsb_first = 1'b0; DI = 15'h7C33; st = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st = 1'b0;
      found = 1'b0;
      for (int j = 0; j < 1000; j++) begin
         if (s_edge == 7) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("abort_edge7_reached", found, 1'b1);
      check("abort_sclk_before", SCLK, 1'b1);
      clr = 1'b1;
      #1;
      check("abort_LOAD", LOAD, 1'b1);
      check("abort_SCLK", SCLK, 1'b0);
      check("abort_MOSI", MOSI, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_DO", DO, '0);
      @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_stay_idle", LOAD, 1'b1);
      check("abort_DO_kept", DO, '0);

      run_frame(2'b00, 1'b0, 15'h4321, 15'h5A5A, 1'b0, lat);
      post_checks("after_abort", lat, 15'h5A5A, 15'h4321);
      repeat (3) @(negedge clk);

`ifdef SPIM_LOOPBACK_EN
      loopback = 1'b1;
      run_frame(2'b00, 1'b0, 15'h2A55, 15'h0000, 1'b0, lat);
      post_checks("loopback", lat, 15'h2A55, 15'h2A55);
      loopback = 1'b0;
      repeat (3) @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master, the next generation of the lab's fixed 15-bit SPI_MASTER. It adds configurable frame width and SCLK divider, all four SPI modes selected per frame, MSB- or LSB-first ordering, and a busy/done handshake. It sits between a parallel data source/sink in the fabric and an external SPI slave.

## Interface
- N, 15: frame width in bits; legal range 2..32.
- DIV, 25: `clk` cycles per SCLK half-period; DIV ≥ 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- clr  in  1  asynchronous, active-high reset.
- st  in  1  start request, sampled on `clk`; acted on only when idle.
- mode  in  2  {CPOL, CPHA}; latched at frame start.
- lsb_first  in  1  1 = LSB shifted first; latched at frame start.
- DI  in  N  transmit word; latched at frame start.
- MISO  in  1  serial data from slave.
- MOSI  out  1  serial data to slave.
- SCLK  out  1  serial clock.
- LOAD  out  1  active-low slave select; high when idle.
- busy  out  1  high from frame start until frame end.
- done  out  1  one-cycle pulse at frame end.
- DO  out  N  received word; updated only at frame end.

## Operation
- States: IDLE, LEAD, SHIFT, TRAIL.
- IDLE:
  - Outputs: LOAD=1, busy=0, SCLK=latched CPOL, MOSI=0.
  - If st=1: latch DI into the tx shift register, latch mode and lsb_first, clear the rx register, set LOAD=0 and busy=1, go to LEAD.
- LEAD:
  - Runs for DIV cycles, then enters SHIFT.
  - CPHA=0: the first data bit is on MOSI from the LOAD falling edge.
  - CPHA=1: MOSI holds 0 until the first SCLK edge.
- SHIFT:
  - Produces 2N SCLK toggles, one every DIV cycles.
  - Odd-numbered edge (leading): CPHA=0 samples MISO; CPHA=1 drives the next bit onto MOSI.
  - Even-numbered edge (trailing): CPHA=0 drives the next bit; CPHA=1 samples MISO.
  - After the 2N-th edge SCLK equals CPOL; go to TRAIL.
- TRAIL:
  - Runs for DIV cycles.
  - Then: DO ← rx register, LOAD=1, busy=0, done=1 for one cycle, return to IDLE.
- Bit order:
  - lsb_first=0: transmit DI[N-1] first; received bits shift in at bit 0 upward, so the first bit received ends in DO[N-1].
  - lsb_first=1: transmit DI[0] first; the first bit received lands in DO[0].
- Counters:
  - Half-period counter is $clog2(DIV+1) bits and counts DIV-1 down to 0 without wrapping.
  - Edge counter is $clog2(2N+1) bits.
- Ignored inputs:
  - st while busy=1 is ignored; no queuing.
  - Changes to mode, lsb_first and DI during a frame have no effect.

## Timing
- Let st be sampled high in IDLE at edge k.
- LOAD falls and busy rises at edge k.
- SCLK edge i (i=1..2N) occurs at edge k+i·DIV.
- done=1, LOAD=1 and the DO update occur at edge k+(2N+1)·DIV, so frame latency is (2N+1)·DIV cycles.
- Back-to-back: st high in the cycle after done is accepted, giving a minimum LOAD-high gap of 1 cycle.
- MISO is sampled directly with no synchroniser. The slave must meet setup/hold relative to `clk` at the sampling edges.
- Reset:
  - clr=1 forces, immediately and independent of `clk`: state=IDLE, SCLK=0, LOAD=1, MOSI=0, busy=0, done=0, DO=0, latched mode=0.
  - A reset mid-frame aborts the frame; DO is not updated with partial data.

## Configuration
- SPIM_LOOPBACK_EN defined:
  - Adds input port `loopback` (1 bit).
  - When loopback=1, the receive path samples the internal MOSI value instead of MISO; external pins behave as normal.
- SPIM_LOOPBACK_EN undefined:
  - The `loopback` port is absent.
  - The receive path always samples MISO.

## Test plan
- Reset: assert clr mid-idle and with st=1 → LOAD=1, SCLK=0, MOSI=0, busy=0, done=0, DO=0 with no clock edge required.
- Mode 0, MSB first:
  - Setup: N=15, DIV=25, DI=15'b111110000110011, MISO=1, st pulse.
  - Response: MOSI bit sequence equals DI MSB first; 15 rising SCLK edges; done at st+775 cycles; DO=15'h7FFF.
- Mode 3, LSB first:
  - Setup: slave model returns 15'h1234; DI=15'h0F0F.
  - Response: SCLK idles high; the slave captures 15'h0F0F; DO=15'h1234.
- Mode 1 and mode 2:
  - Setup: MISO=0, DI=15'h2A55.
  - Response: DO=15'h0000; MOSI changes only on leading (mode 1) or trailing (mode 2) edges as specified.
- Handshake:
  - st pulses during busy are ignored, with frame length unchanged.
  - st in the cycle after done starts a new frame; LOAD is high for exactly 1 cycle.
- Abort and loopback:
  - clr at SCLK edge 7 → immediate idle; next st yields a full 775-cycle frame.
  - With SPIM_LOOPBACK_EN, loopback=1, MISO=0, DI=15'h2A55 → DO=15'h2A55.
